clock_divider_mc: RTL and testbench

- Multi-channel, parametrised successor to the single-channel programmable clock divider.
- Generates N_CH independent divided clocks from the FPGA board clock, plus a per-channel period tick.
- Divisor changes take effect only at period boundaries, so outputs never glitch; a global sync restarts all channels in phase.
- Feeds display multiplexers, baud/tone generators and slow-strobe logic.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clock_divider_mc_if.sv | 12 +
 rtl/clkdiv_channel.sv | 44 ++++
 rtl/clock_divider_mc.sv | 30 +++
 tb/tb_clock_divider_mc.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared limits and bus-slicing helper for the multi-channel clock divider
// Optional duty control is enabled by defining CLKDIV_DUTY_CTRL_EN.
package clkdiv_pkg;
  localparam int CLKDIV_CNT_W_DEFAULT = 27;
  localparam int CLKDIV_N_CH_MAX = 16;
  localparam int CLKDIV_CNT_W_MAX = 32;
  localparam int CLKDIV_BUS_MAX = CLKDIV_N_CH_MAX * CLKDIV_CNT_W_MAX;
  typedef logic [CLKDIV_CNT_W_MAX-1:0] clkdiv_field_t;
  typedef logic [CLKDIV_BUS_MAX-1:0] clkdiv_bus_t;
  // Returns channel k's w-bit field of a packed per-channel bus, zero-extended.
  function automatic clkdiv_field_t clkdiv_slice(input clkdiv_bus_t bus, input int unsigned k, input int unsigned w);
    clkdiv_bus_t s = bus >> (k * w);
    return clkdiv_field_t'(s) & ((clkdiv_field_t'(1) << w) - clkdiv_field_t'(1));
  endfunction
endpackage

// File: rtl/clock_divider_mc_if.sv
// clock_divider_mc_if: control and output bundle of the multi-channel clock divider
interface clock_divider_mc_if #(parameter int N_CH = 4, parameter int CNT_W = 27);
  logic [N_CH-1:0] enable;
  logic [N_CH*CNT_W-1:0] divide;
  logic [N_CH*CNT_W-1:0] high_cnt;
  logic sync;
  logic [N_CH-1:0] clock_out;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] load_ack;
  modport master(output enable, divide, high_cnt, sync, input clock_out, tick, load_ack);
  modport slave(input enable, divide, high_cnt, sync, output clock_out, tick, load_ack);
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel; high_cnt is honoured only when CLKDIV_DUTY_CTRL_EN is defined
module clkdiv_channel import clkdiv_pkg::*; #(
  parameter int CNT_W = CLKDIV_CNT_W_DEFAULT
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_sync,
  input  logic [CNT_W-1:0] i_divide,
  input  logic [CNT_W-1:0] i_high_cnt,
  output logic             o_clock_out,
  output logic             o_tick,
  output logic             o_load_ack
);
  logic [CNT_W-1:0] r_cnt, r_div_q, r_hi_q, w_hi_next;
  logic w_active, w_boundary;
  assign w_active = i_enable && (r_div_q >= CNT_W'(2));
  assign w_boundary = !w_active || i_sync || (r_cnt == r_div_q - CNT_W'(1));
`ifdef CLKDIV_DUTY_CTRL_EN
  assign w_hi_next = (i_high_cnt < i_divide) ? i_high_cnt : i_divide;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^i_high_cnt;
  assign w_hi_next = i_divide >> 1;
`endif
  // Count within the period; shadow the divisor only at boundaries so outputs never glitch.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_div_q <= '0;
      r_hi_q <= '0;
      o_clock_out <= 1'b0;
      o_tick <= 1'b0;
      o_load_ack <= 1'b0;
    end else begin
      r_cnt <= w_boundary ? '0 : r_cnt + CNT_W'(1);
      r_div_q <= w_boundary ? i_divide : r_div_q;
      r_hi_q <= w_boundary ? w_hi_next : r_hi_q;
      o_load_ack <= w_boundary && (i_divide != r_div_q);
      o_clock_out <= w_active && (r_cnt < r_hi_q);
      o_tick <= w_active && (r_cnt == '0);
    end
  end
endmodule

// File: rtl/clock_divider_mc.sv
// clock_divider_mc: N_CH independent glitch-free clock dividers with shared sync (duty control via CLKDIV_DUTY_CTRL_EN)
module clock_divider_mc import clkdiv_pkg::*; #(
  parameter int N_CH = 4,
  parameter int CNT_W = CLKDIV_CNT_W_DEFAULT
) (
  input  logic clock_in,
  input  logic reset_n,
  clock_divider_mc_if.slave bus
);
  clkdiv_bus_t w_div_bus, w_hi_bus;
  logic [N_CH-1:0] w_clock_out, w_tick, w_load_ack;
  assign w_div_bus = clkdiv_bus_t'(bus.divide);
  assign w_hi_bus = clkdiv_bus_t'(bus.high_cnt);
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clkdiv_channel #(.CNT_W(CNT_W)) u_ch (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .i_enable   (bus.enable[k]),
      .i_sync     (bus.sync),
      .i_divide   (CNT_W'(clkdiv_slice(w_div_bus, k, CNT_W))),
      .i_high_cnt (CNT_W'(clkdiv_slice(w_hi_bus, k, CNT_W))),
      .o_clock_out(w_clock_out[k]),
      .o_tick     (w_tick[k]),
      .o_load_ack (w_load_ack[k])
    );
  end
  assign bus.clock_out = w_clock_out;
  assign bus.tick = w_tick;
  assign bus.load_ack = w_load_ack;
endmodule

// File: tb/tb_clock_divider_mc.sv
// tb_clock_divider_mc: randomized self-checking bench against a period-waveform queue model
module tb_clock_divider_mc;
  localparam int N_CH = 4;
  localparam int CNT_W = 27;
  logic clock_in, reset_n;
  int n_cmp = 0, n_bad = 0;
  clock_divider_mc_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();
  clock_divider_mc #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (.clock_in(clock_in), .reset_n(reset_n), .bus(bus));

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Model: each period is a queue of output levels laid out when the period starts.
  int m_div[N_CH];
  bit m_q[N_CH][$];
  logic [N_CH-1:0] exp_co, exp_tk, exp_ack;
  always @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_CH; k++) begin
        m_div[k] = 0;
        m_q[k].delete();
      end
      exp_co = '0;
      exp_tk = '0;
      exp_ack = '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        int d, h;
        bit act;
        d = int'(bus.divide[k*CNT_W +: CNT_W]);
`ifdef CLKDIV_DUTY_CTRL_EN
        h = int'(bus.high_cnt[k*CNT_W +: CNT_W]);
        if (h > d) h = d;
`else
        h = d / 2;
`endif
        act = bus.enable[k] && m_div[k] >= 2;
        exp_co[k] = 1'b0;
        exp_tk[k] = 1'b0;
        exp_ack[k] = 1'b0;
        if (act) begin
          exp_tk[k] = (m_q[k].size() == m_div[k]);
          exp_co[k] = m_q[k].pop_front();
        end
        if (!act || bus.sync || m_q[k].size() == 0) begin
          exp_ack[k] = (d != m_div[k]);
          m_div[k] = d;
          m_q[k].delete();
          for (int i = 0; i < d; i++) m_q[k].push_back(i < h);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic set_ch(input int k, input bit en, input int d, input int hc);
    bus.enable[k] = en;
    bus.divide[k*CNT_W +: CNT_W] = CNT_W'(d);
    bus.high_cnt[k*CNT_W +: CNT_W] = CNT_W'(hc);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.enable = '0;
    bus.divide = '0;
    bus.high_cnt = '0;
    bus.sync = 1'b0;
    repeat (2) begin
      step();
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.load_ack} !== '0) begin
        n_bad++;
        $display("FAIL reset: got co=%b tk=%b ack=%b want all 0", bus.clock_out, bus.tick, bus.load_ack);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_div4();
    set_ch(0, 1, 4, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
        n_bad++;
        $display("FAIL div4 model i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
      end
      n_cmp++;
      if ({bus.clock_out[0], bus.tick[0], bus.load_ack[0]} !== {i >= 2 && ((i - 2) % 4) < 2, i >= 2 && ((i - 2) % 4) == 0, i == 1}) begin
        n_bad++;
        $display("FAIL div4 pattern i=%0d: got co=%b tk=%b ack=%b", i, bus.clock_out[0], bus.tick[0], bus.load_ack[0]);
      end
    end
  endtask

  task automatic test_change();
    int acks = 0;
    bit seen = 0;
    set_ch(0, 1, 5, 0);
    for (int i = 0; i < 30 && !(seen && i > 10); i++) begin
      step();
      seen = bus.tick[0];
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
        n_bad++;
        $display("FAIL div5 i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL div5 tick wait: got no tick want tick within 30 cycles");
    end
    step();
    set_ch(0, 1, 8, 0);
    for (int i = 0; i < 24; i++) begin
      step();
      acks += bus.load_ack[0];
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
        n_bad++;
        $display("FAIL div5to8 i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
      end
    end
    n_cmp++;
    if (acks != 1) begin
      n_bad++;
      $display("FAIL div5to8 ack count: got %0d want 1", acks);
    end
  endtask

  task automatic test_zero_one();
    for (int p = 0; p < 3; p++) begin
      set_ch(0, 1, p, 0);
      for (int i = 0; i < 8; i++) begin
        step();
        n_cmp++;
        if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
          n_bad++;
          $display("FAIL div%0d i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", p, i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
        end
        if (p < 2) begin
          n_cmp++;
          if ({bus.clock_out[0], bus.tick[0]} !== 2'b00) begin
            n_bad++;
            $display("FAIL div%0d idle i=%0d: got co=%b tk=%b want 0 0", p, i, bus.clock_out[0], bus.tick[0]);
          end
        end
      end
    end
  endtask

  task automatic test_sync();
    set_ch(0, 1, 6, 0);
    set_ch(1, 1, 10, 0);
    repeat (3 + $urandom_range(0, 12)) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    step();
    n_cmp++;
    if (bus.tick[1:0] !== 2'b11) begin
      n_bad++;
      $display("FAIL sync align: got tick=%b want 11", bus.tick[1:0]);
    end
    for (int i = 0; i < 40; i++) begin
      if (i % 7 == 3) bus.enable[0] = ~bus.enable[0];
      step();
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
        n_bad++;
        $display("FAIL sync toggle i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
      end
    end
  endtask

  task automatic test_duty();
    int hcs[3] = '{3, 0, 12};
    for (int j = 0; j < 3; j++) begin
      set_ch(2, 1, 10, hcs[j]);
      for (int i = 0; i < 25; i++) begin
        step();
        n_cmp++;
        if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
          n_bad++;
          $display("FAIL duty hc=%0d i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", hcs[j], i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        int k = $urandom_range(0, N_CH - 1);
        set_ch(k, $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0 ? $urandom_range(0, 1) : $urandom_range(2, 17), $urandom_range(0, 20));
      end
      bus.sync = ($urandom_range(0, 40) == 0);
      step();
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
        n_bad++;
        $display("FAIL random i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
      end
    end
    bus.sync = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    set_ch(0, 1, 8, 4);
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      hit = bus.clock_out[0];
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reset_mid wait: got clock_out[0]=0 want 1 within 30 cycles");
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.clock_out, bus.tick, bus.load_ack} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid async: got co=%b tk=%b ack=%b want all 0", bus.clock_out, bus.tick, bus.load_ack);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if ({bus.clock_out, bus.tick, bus.load_ack} !== {exp_co, exp_tk, exp_ack}) begin
        n_bad++;
        $display("FAIL reset_mid resume i=%0d: got co=%b tk=%b ack=%b want co=%b tk=%b ack=%b", i, bus.clock_out, bus.tick, bus.load_ack, exp_co, exp_tk, exp_ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_change();
    test_zero_one();
    test_sync();
    test_duty();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
